// File: rtl/sqrt_dispatch.sv
// Request FIFO and single-outstanding issue controller for the SQRT core.
// Operands are queued, issued one at a time, and returned with their root or a timeout flag.
module sqrt_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 20
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    input  logic [15:0] REQ_DATA,
    output logic        REQ_READY,
    output logic        SQ_IN_VALID,
    output logic [15:0] SQ_IN,
    input  logic        SQ_OUT_VALID,
    input  logic [11:0] SQ_OUT,
    output logic        RES_VALID,
    output logic [15:0] RES_IN,
    output logic [11:0] RES_ROOT,
    output logic        RES_ERR,
    output logic        BUSY
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]   op_q, op_d;
    logic [15:0]   res_in_q, res_in_d;
    logic [11:0]   root_q, root_d;
    logic          err_q, err_d;
    logic [15:0]   mem [DEPTH];
    logic          push;
    logic          pop;

    always_comb begin
        push = REQ_VALID && (count_q != FULL);
        pop  = (state_q == S_ISSUE);
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wait_cnt_d = wait_cnt_q;
        op_d       = op_q;
        res_in_d   = res_in_q;
        root_d     = root_q;
        err_d      = err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                op_d       = mem[rd_ptr_q];
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + TW'(1);
                // A response arriving on the final wait cycle still counts as success.
                if (SQ_OUT_VALID) begin
                    root_d   = SQ_OUT;
                    err_d    = 1'b0;
                    res_in_d = op_q;
                    state_d  = S_RESP;
                end else if (wait_cnt_q == TMAX) begin
                    root_d   = '0;
                    err_d    = 1'b1;
                    res_in_d = op_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                state_d = (count_q != '0) ? S_ISSUE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
            op_q       <= '0;
            res_in_q   <= '0;
            root_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
            op_q       <= op_d;
            res_in_q   <= res_in_d;
            root_q     <= root_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= REQ_DATA;
        end
    end

    assign REQ_READY   = (count_q != FULL);
    assign SQ_IN_VALID = (state_q == S_ISSUE);
    assign SQ_IN       = (state_q == S_ISSUE) ? mem[rd_ptr_q] : op_q;
    assign RES_VALID   = (state_q == S_RESP);
    assign RES_IN      = res_in_q;
    assign RES_ROOT    = root_q;
    assign RES_ERR     = err_q;
    assign BUSY        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_sqrt_dispatch.sv
// Scoreboard bench for sqrt_dispatch with a behavioural SQRT core model.
// Expected results are queued at push time; a negedge monitor pops and compares them.
module tb_sqrt_dispatch;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;

    typedef struct {
        logic [15:0] data;
        logic [11:0] root;
        logic        err;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [11:0] root;
        logic        silent;
        int          lat;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_data;
    logic        req_ready;
    logic        sq_in_valid;
    logic [15:0] sq_in;
    logic        sq_out_valid;
    logic [11:0] sq_out;
    logic        res_valid;
    logic [15:0] res_in;
    logic [11:0] res_root;
    logic        res_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];
    cfg_t cfg_q[$];

    logic        model_busy  = 1'b0;
    int          model_cnt   = 0;
    logic [11:0] model_root  = '0;
    logic        force_ov    = 1'b0;
    logic        ov_genuine  = 1'b0;
    logic        prev_in_valid = 1'b0;
    int          ncyc        = 0;
    int          last_issue_n = 0;
    int          last_ov_n   = 0;

    sqrt_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK         (clk),
        .RST         (rst),
        .REQ_VALID   (req_valid),
        .REQ_DATA    (req_data),
        .REQ_READY   (req_ready),
        .SQ_IN_VALID (sq_in_valid),
        .SQ_IN       (sq_in),
        .SQ_OUT_VALID(sq_out_valid),
        .SQ_OUT      (sq_out),
        .RES_VALID   (res_valid),
        .RES_IN      (res_in),
        .RES_ROOT    (res_root),
        .RES_ERR     (res_err),
        .BUSY        (busy)
    );

    always #5 clk = ~clk;

    // Rounded 8.4 root of the operand, saturated to 12 bits.
    function automatic logic [11:0] ref_root(input logic [15:0] x);
        real r;
        int  v;
        r = $sqrt(real'(x)) * 16.0;
        v = $rtoi(r + 0.5);
        if (v > 4095) v = 4095;
        return 12'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, ncyc);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic silent, input int lat);
        logic accepted;
        logic [11:0] r;
        accepted = 1'b0;
        r = ref_root(d);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_data  = d;
            if (req_ready) begin
                accepted = 1'b1;
                exp_q.push_back('{data: d, root: silent ? 12'h000 : r, err: silent});
                cfg_q.push_back('{data: d, root: r, silent: silent, lat: lat});
                @(posedge clk);
                #1;
                break;
            end
        end
        req_valid = 1'b0;
        if (!accepted) checkOutput("push_accept", req_ready, 1);
    endtask

    task automatic waitIdle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checkOutput("drain_busy", busy, 0);
            checkOutput("drain_pending", exp_q.size(), 0);
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_sq_in_valid", sq_in_valid, 0);
        checkOutput("rst_sq_in", sq_in, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_in", res_in, 0);
        checkOutput("rst_res_root", res_root, 0);
        checkOutput("rst_res_err", res_err, 0);
        checkOutput("rst_busy", busy, 0);
    endtask

    // SQRT core model: answers after the configured latency unless told to stay silent.
    initial begin
        sq_out_valid = 1'b0;
        sq_out       = '0;
        forever begin
            @(posedge clk);
            #1;
            sq_out_valid = 1'b0;
            ov_genuine   = 1'b0;
            if (force_ov) begin
                sq_out_valid = 1'b1;
                sq_out       = 12'h5A5;
                force_ov     = 1'b0;
            end else if (model_busy) begin
                if (model_cnt <= 1) begin
                    sq_out_valid = 1'b1;
                    sq_out       = model_root;
                    ov_genuine   = 1'b1;
                    model_busy   = 1'b0;
                end else begin
                    model_cnt--;
                end
            end
        end
    end

    // Monitor: issue checks feed the core model, results are compared against the scoreboard.
    initial begin
        cfg_t c;
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst) begin
                if (sq_in_valid) begin
                    checkOutput("sq_in_valid_single", prev_in_valid, 0);
                    checkOutput("one_outstanding", model_busy, 0);
                    if (cfg_q.size() == 0) begin
                        checkOutput("issue_expected", sq_in_valid, 0);
                    end else begin
                        c = cfg_q.pop_front();
                        checkOutput("sq_in", sq_in, c.data);
                        model_busy   = !c.silent;
                        model_cnt    = c.lat;
                        model_root   = c.root;
                        last_issue_n = ncyc;
                    end
                end
                if (sq_out_valid && ov_genuine) last_ov_n = ncyc;
                if (res_valid) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("res_valid_unexpected", res_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("res_in", res_in, e.data);
                        checkOutput("res_root", res_root, e.root);
                        checkOutput("res_err", res_err, e.err);
                        if (e.err) checkOutput("timeout_latency", ncyc - last_issue_n, TIMEOUT + 1);
                        else       checkOutput("result_latency", ncyc - last_ov_n, 1);
                    end
                end
            end
            prev_in_valid = sq_in_valid;
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkResetValues();

        $display("[TB] single request");
        applyStimulus(16'd4, 1'b0, 3);
        waitIdle();

        $display("[TB] rounding and extremes");
        applyStimulus(16'd2, 1'b0, 2);
        applyStimulus(16'd0, 1'b0, 5);
        applyStimulus(16'd65500, 1'b0, 1);
        waitIdle();
        checkOutput("ref_root_2", ref_root(16'd2), 12'h017);

        $display("[TB] spurious OUT_VALID in IDLE");
        @(negedge clk);
        force_ov = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idle_busy", busy, 0);

        $display("[TB] spurious OUT_VALID in ISSUE");
        applyStimulus(16'd16, 1'b0, 4);
        @(negedge clk);
        force_ov = 1'b1;
        waitIdle();

        $display("[TB] fill");
        applyStimulus(16'd1, 1'b1, 1);
        for (int i = 2; i <= 5; i++) applyStimulus(16'(i), 1'b0, 2);
        @(negedge clk);
        checkOutput("fill_ready_low", req_ready, 0);
        applyStimulus(16'd6, 1'b0, 3);
        waitIdle();

        $display("[TB] timeout");
        applyStimulus(16'd9, 1'b1, 1);
        applyStimulus(16'd25, 1'b0, 2);
        waitIdle();

        $display("[TB] reset mid-wait");
        applyStimulus(16'd100, 1'b1, 1);
        applyStimulus(16'd200, 1'b0, 2);
        applyStimulus(16'd300, 1'b0, 2);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        cfg_q.delete();
        model_busy = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkResetValues();
        force_ov = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("post_reset_busy", busy, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(3, 0));
            repeat (gap) @(negedge clk);
            applyStimulus(16'($urandom), ($urandom_range(7, 0) == 0), int'($urandom_range(TIMEOUT, 1)));
        end
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
